// File: rtl/sabr_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sabr_mul_arbiter
// Brief   : Round-robin sharing of one pipelined 13s x 71s multiplier among
//           N_REQ requesters, with tag-based result routing and ce stalling.
// Revision: 1.0
// ============================================================================
module sabr_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*13-1:0]   req_din0,
    input  logic [N_REQ*71-1:0]   req_din1,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [70:0]           rsp_dout,
    output logic                  mul_ce,
    output logic [12:0]           mul_din0,
    output logic [70:0]           mul_din1,
    input  logic [70:0]           mul_dout,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_cnt
);
    localparam int              ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ID_W-1:0] C_LAST_RST = ID_W'(N_REQ - 1);

    logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]    tag_id_q [MUL_LAT];
    logic [ID_W-1:0]    tag_id_d [MUL_LAT];
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               w_head_valid;
    logic [ID_W-1:0]    w_head_id;
    logic               w_head_block;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_cand;

    assign w_head_valid = tag_vld_q[MUL_LAT-1];
    assign w_head_id    = tag_id_q[MUL_LAT-1];

    // The head tag is aligned with mul_dout; a refused head freezes the pipe.
    always_comb begin
        w_head_block = 1'b0;
        rsp_valid    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_head_valid && (w_head_id == ID_W'(k))) begin
                rsp_valid[k] = 1'b1;
                w_head_block = ~rsp_ready[k];
            end
        end
    end

    assign mul_ce    = ~w_head_block;
    assign rsp_dout  = mul_dout;
    assign busy      = |tag_vld_q;
    assign stall_cnt = stall_cnt_q;

    // Search starts one past the last winner so every valid requester is served in turn.
    always_comb begin
        req_ready = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = last_grant_q;
        w_cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = ID_W'((int'(last_grant_q) + i) % N_REQ);
            if (!w_gnt_any && mul_ce && req_valid[w_cand]) begin
                w_gnt_any         = 1'b1;
                w_gnt_id          = w_cand;
                req_ready[w_cand] = 1'b1;
            end
        end
    end

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_ready[k]) begin
                mul_din0 = req_din0[13*k +: 13];
                mul_din1 = req_din1[71*k +: 71];
            end
        end
    end

    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_id_d  = tag_id_q;
        if (mul_ce) begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_id_d[i]  = tag_id_q[i-1];
            end
            tag_vld_d[0] = w_gnt_any;
            tag_id_d[0]  = w_gnt_id;
        end
        last_grant_d = w_gnt_any ? w_gnt_id : last_grant_q;
        stall_cnt_d  = stall_cnt_q;
        if (!mul_ce && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q    <= '0;
            last_grant_q <= C_LAST_RST;
            stall_cnt_q  <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q    <= tag_vld_d;
            last_grant_q <= last_grant_d;
            stall_cnt_q  <= stall_cnt_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sabr_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sabr_mul_arbiter
// Brief   : Directed self-checking bench with a behavioural 4-stage multiplier.
// Revision: 1.0
// ============================================================================
module tb_sabr_mul_arbiter;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [51:0]  req_din0 = '0;
    logic [283:0] req_din1 = '0;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready = 4'b1111;
    logic [70:0]  rsp_dout;
    logic         mul_ce;
    logic [12:0]  mul_din0;
    logic [70:0]  mul_din1;
    logic [70:0]  mul_dout;
    logic         busy;
    logic [3:0]   stall_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    sabr_mul_arbiter #(.N_REQ(4), .MUL_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: input register plus three output buffers, all ce-gated.
    logic signed [83:0] full_prod;
    logic [70:0]        mp [4];
    assign full_prod = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout  = mp[3];
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= full_prod[70:0];
            mp[1] <= mp[0];
            mp[2] <= mp[1];
            mp[3] <= mp[2];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int k, input logic [12:0] a, input logic [70:0] b);
        req_din0[13*k +: 13] = a;
        req_din1[71*k +: 71] = b;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = 4'b1111;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 4'b0110;
        #3;
        total_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (mul_ce !== 1'b1) $display("FAIL rst_mul_ce: got %b expected 1", mul_ce); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0010) $display("FAIL rst_req_ready: got %b expected 0010", req_ready); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy_after_edge: got %b expected 0", busy); else pass_cnt++;
        req_valid = '0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0]  e_v;
        logic [70:0] e_d;
        set_ops(0, 13'd3, -71'sd5);
        req_valid = 4'b0001;
        #3;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready); else pass_cnt++;
        total_cnt++; if (mul_din0 !== 13'd3) $display("FAIL single_din0: got %h expected 0003", mul_din0); else pass_cnt++;
        e_d = -71'sd5;
        total_cnt++; if (mul_din1 !== e_d) $display("FAIL single_din1: got %h expected %h", mul_din1, e_d); else pass_cnt++;
        tick();
        req_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            #3;
            e_v = (c == 4) ? 4'b0001 : 4'b0000;
            total_cnt++; if (rsp_valid !== e_v) $display("FAIL single_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_v); else pass_cnt++;
            total_cnt++; if (busy !== (c <= 4)) $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, (c <= 4)); else pass_cnt++;
            if (c == 1) begin
                total_cnt++; if (mul_din1 !== 71'd0) $display("FAIL single_idle_din1: got %h expected 0", mul_din1); else pass_cnt++;
            end
            if (c == 4) begin
                e_d = -71'sd15;
                total_cnt++; if (rsp_dout !== e_d) $display("FAIL single_dout: got %h expected %h", rsp_dout, e_d); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        logic [70:0] prod [4];
        logic [3:0]  e_r, e_v;
        apply_reset();
        set_ops(0, 13'd2, 71'd1000);
        set_ops(1, -13'sd3, 71'd1000);
        set_ops(2, 13'd5, -71'sd1000);
        set_ops(3, 13'd7, 71'd123456789);
        prod[0] = 71'd2000;
        prod[1] = -71'sd3000;
        prod[2] = -71'sd5000;
        prod[3] = 71'd864197523;
        req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) req_valid = '0;
            #3;
            e_r = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            e_v = (c >= 4) ? (4'b0001 << ((c - 4) % 4)) : 4'b0000;
            total_cnt++; if (req_ready !== e_r) $display("FAIL fair_ready c=%0d: got %b expected %b", c, req_ready, e_r); else pass_cnt++;
            total_cnt++; if (rsp_valid !== e_v) $display("FAIL fair_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_v); else pass_cnt++;
            if (c >= 4) begin
                total_cnt++; if (rsp_dout !== prod[(c-4)%4]) $display("FAIL fair_dout c=%0d: got %h expected %h", c, rsp_dout, prod[(c-4)%4]); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_extremes();
        logic [70:0] e0, e1;
        logic [3:0]  e_v;
        apply_reset();
        set_ops(0, 13'h1000, {1'b0, {70{1'b1}}});
        set_ops(1, 13'd4095, {1'b1, 70'd0});
        e0 = 71'd4096;
        e1 = {1'b1, 70'd0};
        req_valid = 4'b0011;
        #3;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL ext_ready0: got %b expected 0001", req_ready); else pass_cnt++;
        tick();
        req_valid = 4'b0010;
        #3;
        total_cnt++; if (req_ready !== 4'b0010) $display("FAIL ext_ready1: got %b expected 0010", req_ready); else pass_cnt++;
        tick();
        req_valid = '0;
        for (int c = 2; c <= 5; c++) begin
            #3;
            e_v = (c == 4) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0000;
            total_cnt++; if (rsp_valid !== e_v) $display("FAIL ext_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_v); else pass_cnt++;
            if (c == 4) begin
                total_cnt++; if (rsp_dout !== e0) $display("FAIL ext_dout_neg4096: got %h expected %h", rsp_dout, e0); else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++; if (rsp_dout !== e1) $display("FAIL ext_dout_4095: got %h expected %h", rsp_dout, e1); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [70:0] prod [4];
        logic [3:0]  e_r, e_v, e_s;
        logic        e_ce;
        logic [70:0] e_d;
        apply_reset();
        set_ops(0, 13'd11, 71'd100);
        set_ops(1, -13'sd12, 71'd200);
        set_ops(2, 13'd13, -71'sd300);
        set_ops(3, -13'sd14, 71'd400);
        prod[0] = 71'd1100;
        prod[1] = -71'sd2400;
        prod[2] = -71'sd3900;
        prod[3] = -71'sd5600;
        for (int c = 0; c < 14; c++) begin
            case (c)
                0:  req_valid = 4'b1111;
                4:  req_valid = 4'b0000;
                6:  begin req_valid = 4'b0010; rsp_ready = 4'b1011; end
                9:  rsp_ready = 4'b1111;
                10: req_valid = 4'b0000;
                default: ;
            endcase
            #3;
            case (c)
                0, 1, 2, 3: e_r = 4'b0001 << c;
                9:          e_r = 4'b0010;
                default:    e_r = 4'b0000;
            endcase
            case (c)
                4:          e_v = 4'b0001;
                5:          e_v = 4'b0010;
                6, 7, 8, 9: e_v = 4'b0100;
                10:         e_v = 4'b1000;
                13:         e_v = 4'b0010;
                default:    e_v = 4'b0000;
            endcase
            e_ce = !(c >= 6 && c <= 8);
            e_s  = (c <= 6) ? 4'd0 : (c >= 9) ? 4'd3 : 4'(c - 6);
            total_cnt++; if (req_ready !== e_r) $display("FAIL bp_ready c=%0d: got %b expected %b", c, req_ready, e_r); else pass_cnt++;
            total_cnt++; if (rsp_valid !== e_v) $display("FAIL bp_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_v); else pass_cnt++;
            total_cnt++; if (mul_ce !== e_ce) $display("FAIL bp_mul_ce c=%0d: got %b expected %b", c, mul_ce, e_ce); else pass_cnt++;
            total_cnt++; if (stall_cnt !== e_s) $display("FAIL bp_stall_cnt c=%0d: got %0d expected %0d", c, stall_cnt, e_s); else pass_cnt++;
            if (e_v != 4'b0000) begin
                e_d = '0;
                for (int k = 0; k < 4; k++) if (e_v[k]) e_d = prod[k];
                total_cnt++; if (rsp_dout !== e_d) $display("FAIL bp_dout c=%0d: got %h expected %h", c, rsp_dout, e_d); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        logic [3:0] e_s, e_v;
        apply_reset();
        set_ops(0, 13'd9, 71'd9);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        for (int j = 0; j < 22; j++) begin
            if (j == 0)  rsp_ready = 4'b1110;
            if (j == 20) rsp_ready = 4'b1111;
            #3;
            e_s = (j > 15) ? 4'd15 : 4'(j);
            e_v = (j <= 20) ? 4'b0001 : 4'b0000;
            total_cnt++; if (stall_cnt !== e_s) $display("FAIL sat_stall_cnt j=%0d: got %0d expected %0d", j, stall_cnt, e_s); else pass_cnt++;
            total_cnt++; if (rsp_valid !== e_v) $display("FAIL sat_rsp_valid j=%0d: got %b expected %b", j, rsp_valid, e_v); else pass_cnt++;
            total_cnt++; if (mul_ce !== (j >= 20)) $display("FAIL sat_mul_ce j=%0d: got %b expected %b", j, mul_ce, (j >= 20)); else pass_cnt++;
            if (j == 20) begin
                total_cnt++; if (rsp_dout !== 71'd81) $display("FAIL sat_dout: got %h expected 81", rsp_dout); else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        logic [3:0] e_r, e_v;
        set_ops(0, 13'd3, 71'd6);
        set_ops(1, 13'd4, 71'd7);
        set_ops(2, 13'd5, 71'd8);
        req_valid = 4'b0111;
        for (int c = 0; c < 9; c++) begin
            if (c == 3) begin req_valid = 4'b1111; reset = 1'b0; end
            if (c == 4) reset = 1'b1;
            if (c == 5) req_valid = 4'b0000;
            #3;
            case (c)
                0:       e_r = 4'b0010;
                1:       e_r = 4'b0100;
                2, 3, 4: e_r = 4'b0001;
                default: e_r = 4'b0000;
            endcase
            e_v = (c == 8) ? 4'b0001 : 4'b0000;
            total_cnt++; if (req_ready !== e_r) $display("FAIL mid_ready c=%0d: got %b expected %b", c, req_ready, e_r); else pass_cnt++;
            total_cnt++; if (rsp_valid !== e_v) $display("FAIL mid_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, e_v); else pass_cnt++;
            if (c == 0) begin
                total_cnt++; if (stall_cnt !== 4'd15) $display("FAIL mid_stall_before: got %0d expected 15", stall_cnt); else pass_cnt++;
            end
            if (c == 3) begin
                total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else pass_cnt++;
                total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL mid_stall_cleared: got %0d expected 0", stall_cnt); else pass_cnt++;
                total_cnt++; if (mul_ce !== 1'b1) $display("FAIL mid_mul_ce: got %b expected 1", mul_ce); else pass_cnt++;
            end
            if (c == 8) begin
                total_cnt++; if (rsp_dout !== 71'd18) $display("FAIL mid_dout: got %h expected 18", rsp_dout); else pass_cnt++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_extremes();
        test_backpressure();
        test_saturation();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sabr_mul_arbiter.md
Name: sabr_mul_arbiter

Overview:
- Round-robin arbiter that shares one pipelined signed multiplier (13s x 71s -> 71, SABR_mul_13s_71s_71_5_0 instance, external to this block) among N requesters in the SABR path-update datapath.
- Accepts one operand pair per cycle and tags each operation with its requester ID.
- Routes each product back to its requester after the multiplier latency.
- Stalls the shared pipeline through its clock-enable when the destination requester cannot take a result.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 4, multiplier latency in ce-enabled clock edges (input register plus 3 output buffers).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester operand valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit set.
- req_din0  input  N_REQ*13  packed signed 13-bit operands; requester k at bits [13k+12:13k].
- req_din1  input  N_REQ*71  packed signed 71-bit operands; requester k at bits [71k+70:71k].
- rsp_valid  output  N_REQ  per-requester result valid; at most one bit set.
- rsp_ready  input  N_REQ  per-requester result accept.
- rsp_dout  output  71  result, shared by all requesters, qualified by rsp_valid.
- mul_ce  output  1  clock enable to the multiplier.
- mul_din0  output  13  multiplier operand 0.
- mul_din1  output  71  multiplier operand 1.
- mul_dout  input  71  multiplier result.
- busy  output  1  high while any tag in the tag pipe is valid.
- stall_cnt  output  CNT_W  number of cycles with mul_ce=0; saturates at all-ones.

Behaviour:
- Tag pipe: MUL_LAT entries, each holding {valid, id[clog2(N_REQ)-1:0]}.
  - Advances only when mul_ce=1. Entry 0 is loaded with the grant of that cycle, or valid=0 if there is no grant.
  - The head entry (MUL_LAT-1) aligns with mul_dout.
- head_valid = head.valid.
- Stall: mul_ce = ~(head_valid & ~rsp_ready[head.id]). mul_ce is combinational.
- Responses:
  - rsp_valid[k] = head_valid & (head.id==k).
  - rsp_dout = mul_dout, passed through.
  - rsp_valid and rsp_dout hold stable while stalled; the multiplier holds its state under ce=0.
- Arbitration:
  - Round-robin pointer last_grant. Search order is last_grant+1, ..., wrapping modulo N_REQ.
  - The first k with req_valid[k] wins, only if mul_ce=1.
  - req_ready[k] = grant[k]. A transfer occurs when req_valid[k] & req_ready[k].
  - last_grant updates only on a transfer.
  - No grants are issued while mul_ce=0.
- Operand mux:
  - mul_din0/mul_din1 = the winner's operands.
  - With no grant, both are driven to 0.
- Latency: a result is presented on rsp_dout exactly MUL_LAT ce-enabled edges after its accepting edge. With no stalls that is 4 cycles.
- Throughput: 1 operation per cycle with no stalls. A requester may be granted again only after the others that are valid have been served.
- Arithmetic: the product is the low 71 bits of the full 84-bit signed product (two's-complement wrap, no saturation). This is inherited from the multiplier; the arbiter does not modify data.
- Simultaneous events:
  - A head result delivered (rsp_ready=1) and a new grant in the same cycle are both legal.
  - A requester may issue and receive in the same cycle.
- stall_cnt increments every cycle mul_ce=0 and saturates at 2^CNT_W-1. It is cleared only by reset.
- Reset (async, reset=0):
  - All tag valid bits = 0, last_grant = N_REQ-1 (so requester 0 has first priority), stall_cnt = 0.
  - Resulting outputs: rsp_valid = 0, busy = 0, mul_ce = 1, req_ready follows req_valid priority.
  - Reset mid-operation discards all in-flight products. Stale multiplier contents are masked by the cleared tags.
- Deassertion of reset is synchronised externally; no grant occurs on the deasserting edge other than by normal rules.

Test Plan:
- Single op: req_valid[0]=1, din0=3, din1=-5 for 1 cycle -> req_ready[0]=1 that cycle; rsp_valid[0]=1 with rsp_dout=-15 (71-bit two's complement) exactly 4 cycles later; busy high for cycles 1-4.
- Fairness: all 4 requesters held valid continuously with rsp_ready=all ones -> grant sequence 0,1,2,3,0,1,...; one result per cycle from cycle 4; each rsp_dout matches its requester's din0*din1.
- Backpressure: requesters 0..3 issue back-to-back; rsp_ready[2]=0 for 3 cycles when requester 2's result reaches the head -> mul_ce=0 for 3 cycles; no req_ready asserted; rsp_dout stable; stall_cnt=3; then deliver in order with no loss or duplication.
- Extremes: din0=-4096, din1=2^70-1 -> rsp_dout = low 71 bits of -4096*(2^70-1) = 4096; din0=4095, din1=-2^70 -> rsp_dout = low 71 bits (= -2^70, i.e. bit 70 set, others 0).
- Reset mid-op: 3 ops in flight, pulse reset low for 1 cycle -> rsp_valid never asserts for them; busy=0; stall_cnt=0; next request from requester 0 wins first.
- Saturation: CNT_W=4 build, hold rsp_ready low on a valid head for 20 cycles -> stall_cnt sticks at 15.
